// File: rtl/cdb_rr_arbiter4.sv
// Round-robin arbiter for the shared CDB among 4 FUs; optional stats counters via CDB_ARB_STATS_EN.
// Latency: grant/sel combinational in the request cycle, CDB broadcast registered one cycle later.
// Backpressure: stall or flush suppresses the grant, so requesters keep holding req/tag/data.
module cdb_rr_arbiter4 #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*TAG_W-1:0]    fu_tag,
    input  logic [4*DATA_W-1:0]   fu_data,
    input  logic                  stall,
    input  logic                  flush,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic                  cdb_valid,
    output logic [TAG_W-1:0]      cdb_tag,
    output logic [DATA_W-1:0]     cdb_data
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [4*16-1:0]       grant_cnt,
    output logic [15:0]           conflict_cnt
`endif
);

    logic [1:0] ptr;
    logic [1:0] win_idx;
    logic       win_found;
    logic [1:0] cand;
    logic       grant_en;

    // Scan from the priority pointer upward, wrapping modulo 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign grant_en = win_found && !stall && !flush && !reset;

    always_comb begin
        gnt = 4'b0000;
        sel = 2'd0;
        if (grant_en) begin
            gnt = 4'b0001 << win_idx;
            sel = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= 2'd0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            cdb_valid <= grant_en;
            if (grant_en) begin
                ptr      <= win_idx + 2'd1;
                cdb_tag  <= fu_tag[win_idx*TAG_W +: TAG_W];
                cdb_data <= fu_data[win_idx*DATA_W +: DATA_W];
            end
        end
    end

`ifdef CDB_ARB_STATS_EN
    logic multi_req;
    assign multi_req = (req & (req - 4'd1)) != 4'd0;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt    <= '0;
            conflict_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (gnt[i] && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
            if (grant_en && multi_req && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_rr_arbiter4.sv
// Bench for cdb_rr_arbiter4: vector table for grant/sel, scoreboard queue for the registered CDB.
module tb_cdb_rr_arbiter4;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [3:0]          req;
    logic [4*TAG_W-1:0]  fu_tag;
    logic [4*DATA_W-1:0] fu_data;
    logic                stall;
    logic                flush;
    logic [3:0]          gnt;
    logic [1:0]          sel;
    logic                cdb_valid;
    logic [TAG_W-1:0]    cdb_tag;
    logic [DATA_W-1:0]   cdb_data;

    always #5 clk = ~clk;

    cdb_rr_arbiter4 #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .fu_tag    (fu_tag),
        .fu_data   (fu_data),
        .stall     (stall),
        .flush     (flush),
        .gnt       (gnt),
        .sel       (sel),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       stall;
        logic       flush;
        logic [3:0] gnt;
        logic [1:0] sel;
    } vec_t;

    typedef struct {
        logic              vld;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic [TAG_W-1:0]  hold_tag  = '0;
    logic [DATA_W-1:0] hold_data = '0;

    function automatic logic [DATA_W-1:0] fu_dat(int c, int i);
        return DATA_W'(32'hD000_0000 + c * 16 + i);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic run(vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset = v.rst;
        req   = v.req;
        stall = v.stall;
        flush = v.flush;
        for (int i = 0; i < 4; i++) begin
            fu_tag[i*TAG_W +: TAG_W]    = TAG_W'(i + 1);
            fu_data[i*DATA_W +: DATA_W] = fu_dat(cyc, i);
        end
        #2;
        chk("gnt", 64'(gnt), 64'(v.gnt));
        chk("sel", 64'(sel), 64'(v.sel));
        if (v.rst) begin
            e.vld = 1'b0; e.tag = '0; e.data = '0;
        end else if (v.gnt != 4'b0000) begin
            e.vld = 1'b1; e.tag = TAG_W'(v.sel + 1); e.data = fu_dat(cyc, int'(v.sel));
        end else begin
            e.vld = 1'b0; e.tag = hold_tag; e.data = hold_data;
        end
        hold_tag  = e.tag;
        hold_data = e.data;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty cyc=%0d got 0 entries expected 1", cyc);
        end else begin
            got = sb.pop_front();
            chk("cdb_valid", 64'(cdb_valid), 64'(got.vld));
            chk("cdb_tag",   64'(cdb_tag),   64'(got.tag));
            chk("cdb_data",  64'(cdb_data),  64'(got.data));
        end
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d got no finish expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req = '0; stall = 1'b0; flush = 1'b0; fu_tag = '0; fu_data = '0;

        // rst, req, stall, flush, exp gnt, exp sel
        vecs.push_back('{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0});
        vecs.push_back('{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0});
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0});
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0010, 2'd1});
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0100, 2'd2});
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 2'd3});
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0});
        vecs.push_back('{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1});
        vecs.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0});
        vecs.push_back('{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1});
        vecs.push_back('{1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 2'd0});
        vecs.push_back('{1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 2'd0});
        vecs.push_back('{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0});
        vecs.push_back('{1'b0, 4'b1001, 1'b0, 1'b0, 4'b1000, 2'd3});
        vecs.push_back('{1'b0, 4'b1001, 1'b0, 1'b0, 4'b0001, 2'd0});
        vecs.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0});

        foreach (vecs[i]) run(vecs[i]);

        // Grant FU1, flush next cycle, then reset: broadcast, drop, zeroed state.
        run('{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1});
        run('{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 2'd0});
        run('{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0});
        run('{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0});

        // Reset in the cycle right after a grant, then prove ptr returned to 0.
        run('{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0});
        run('{1'b0, 4'b1010, 1'b0, 1'b0, 4'b0010, 2'd1});
        run('{1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, 2'd3});

        // Winner 3 wrapped ptr to 0: full contention rotates 0,1,2,3 twice.
        for (int k = 0; k < 8; k++) begin
            run('{1'b0, 4'b1111, 1'b0, 1'b0, 4'(4'b0001 << (k % 4)), 2'(k % 4)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
